// File: rtl/rvga_lsu_if.sv
// Load/store unit bus bundle: execute-side op channel, data-memory request and
// response channels, and the writeback result channel. Names are seen from the LSU.
interface rvga_lsu_if #(
    parameter int addr_width_p = 32
);
    logic                    exe_v_i;
    logic                    exe_ready_o;
    logic                    exe_load_i;
    logic                    exe_store_i;
    logic [2:0]              exe_op_i;
    logic [addr_width_p-1:0] exe_addr_i;
    logic [31:0]             exe_wdata_i;

    logic                    mem_v_o;
    logic                    mem_ready_i;
    logic                    mem_we_o;
    logic [addr_width_p-1:0] mem_addr_o;
    logic [3:0]              mem_wmask_o;
    logic [31:0]             mem_wdata_o;
    logic                    mem_resp_v_i;
    logic [31:0]             mem_rdata_i;

    logic                    wb_v_o;
    logic                    wb_ready_i;
    logic [31:0]             wb_data_o;
    logic                    wb_err_o;

    // The LSU side
    modport master (
        input  exe_v_i, exe_load_i, exe_store_i, exe_op_i, exe_addr_i, exe_wdata_i,
        output exe_ready_o,
        output mem_v_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
        input  mem_ready_i, mem_resp_v_i, mem_rdata_i,
        output wb_v_o, wb_data_o, wb_err_o,
        input  wb_ready_i
    );

    // Execute, memory and writeback as seen from outside the LSU
    modport slave (
        output exe_v_i, exe_load_i, exe_store_i, exe_op_i, exe_addr_i, exe_wdata_i,
        input  exe_ready_o,
        input  mem_v_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
        output mem_ready_i, mem_resp_v_i, mem_rdata_i,
        input  wb_v_o, wb_data_o, wb_err_o,
        output wb_ready_i
    );
endinterface

// File: rtl/rvga_lsu.sv
// Load/store unit: one op at a time, word-aligned memory requests with byte lanes,
// sign/zero-extended load return, misaligned/illegal ops answered without memory.
module rvga_lsu #(
    parameter int addr_width_p = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    rvga_lsu_if.master    lsu_io
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    store_q, store_d;
    logic [31:0]             data_q, data_d;
    logic                    err_q, err_d;

    logic        op_legal, illegal, misaligned;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata, shifted, extracted;

    // Decode the incoming op for legality and alignment before anything is latched
    always_comb begin
        case (lsu_io.exe_op_i)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = lsu_io.exe_load_i;
            default:                op_legal = 1'b0;
        endcase
        illegal    = (lsu_io.exe_load_i == lsu_io.exe_store_i) || !op_legal;
        misaligned = ((lsu_io.exe_op_i[1:0] == 2'b01) && lsu_io.exe_addr_i[0]) ||
                     ((lsu_io.exe_op_i[1:0] == 2'b10) && (lsu_io.exe_addr_i[1:0] != 2'b00));
    end

    // Store byte lanes and load extraction from the latched op
    always_comb begin
        case (op_q[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
        shifted = lsu_io.mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extracted = {24'd0, shifted[7:0]};
            3'b101:  extracted = {16'd0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // Next-state logic: accept, request, wait for read data, hold result
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        store_d = store_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (lsu_io.exe_v_i) begin
                op_d    = lsu_io.exe_op_i;
                addr_d  = lsu_io.exe_addr_i;
                wdata_d = lsu_io.exe_wdata_i;
                store_d = lsu_io.exe_store_i;
                data_d  = 32'd0;
                err_d   = illegal || misaligned;
                state_d = (illegal || misaligned) ? DONE : REQ;
            end
            REQ: if (lsu_io.mem_ready_i) begin
                state_d = store_q ? DONE : RESP;
            end
            RESP: if (lsu_io.mem_resp_v_i) begin
                data_d  = extracted;
                state_d = DONE;
            end
            default: if (lsu_io.wb_ready_i) begin
                state_d = IDLE;
            end
        endcase
    end

    // State and op registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            store_q <= 1'b0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign lsu_io.exe_ready_o = (state_q == IDLE);
    assign lsu_io.mem_v_o     = (state_q == REQ);
    assign lsu_io.mem_we_o    = lsu_io.mem_v_o && store_q;
    assign lsu_io.mem_addr_o  = {addr_q[addr_width_p-1:2], 2'b00};
    assign lsu_io.mem_wmask_o = store_q ? lane_mask : 4'b0000;
    assign lsu_io.mem_wdata_o = store_q ? lane_wdata : 32'd0;
    assign lsu_io.wb_v_o      = (state_q == DONE);
    assign lsu_io.wb_data_o   = lsu_io.wb_v_o ? data_q : 32'd0;
    assign lsu_io.wb_err_o    = lsu_io.wb_v_o && err_q;
endmodule

// File: tb/tb_rvga_lsu.sv
// Scoreboard bench for rvga_lsu: a byte-level reference memory predicts every
// memory request and writeback result; separate monitors pop and compare.
module tb_rvga_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvga_lsu_if #(.addr_width_p(32)) bus ();
    rvga_lsu #(.addr_width_p(32)) dut (.clk_i(clk), .reset_n_i(rst_n), .lsu_io(bus));

    typedef struct {logic [31:0] data; logic err; int c0; int lat;} wb_exp_t;
    typedef struct {logic we; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata;} mem_exp_t;

    wb_exp_t     wbq[$];
    mem_exp_t    mq[$];
    logic [31:0] dmem[128];   // memory as the bus sees it, 0x100..0x2FF
    logic [7:0]  rmem[512];   // reference bytes, same window
    int n_chk = 0, n_pass = 0, cyc = 0, n_done = 0;
    int mode = 0;             // 0 zero-wait, 1 random waits, 2 fixed waits
    int fix_stall = 0, fix_lat = 0, fix_wbst = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    task automatic set_word(int a, logic [31:0] w);
        dmem[(a - 256) >> 2] = w;
        for (int i = 0; i < 4; i++) rmem[a - 256 + i] = w[8*i +: 8];
    endtask

    // Predict the outcome of one op from the access rules and the reference bytes
    task automatic expect_op(bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                             logic [31:0] wd, output wb_exp_t e);
        bit legal, mis;
        int sz, off;
        logic [31:0] v;
        mem_exp_t me;
        legal = (ld != st) && (st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5));
        sz = 1 << f3[1:0];
        mis = (a % sz) != 0;
        off = int'(a) - 256;
        e.c0 = 0;
        if (!legal || mis) begin
            e.data = 0; e.err = 1'b1; e.lat = 1;
        end else if (st) begin
            for (int i = 0; i < sz; i++) rmem[off + i] = wd[8*i +: 8];
            me.we = 1'b1;
            me.addr = a & ~32'd3;
            me.mask = 4'(((1 << sz) - 1) << (a % 4));
            me.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
            mq.push_back(me);
            e.data = 0; e.err = 1'b0; e.lat = 2;
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = rmem[off + i];
            if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
            me.we = 1'b0; me.addr = a & ~32'd3; me.mask = 0; me.wdata = 0;
            mq.push_back(me);
            e.data = v; e.err = 1'b0; e.lat = 3;
        end
        if (mode != 0) e.lat = -1;
    endtask

    task automatic drive_op(bit ld, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        bus.exe_v_i = 1'b1; bus.exe_load_i = ld; bus.exe_store_i = st;
        bus.exe_op_i = f3; bus.exe_addr_i = a; bus.exe_wdata_i = wd;
    endtask

    task automatic idle_op();
        bus.exe_v_i = 1'b0; bus.exe_load_i = 1'($urandom); bus.exe_store_i = 1'($urandom);
        bus.exe_op_i = 3'($urandom); bus.exe_addr_i = $urandom; bus.exe_wdata_i = $urandom;
    endtask

    task automatic issue(bit ld, bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        wb_exp_t e;
        int tgt, n;
        expect_op(ld, st, f3, a, wd, e);
        @(negedge clk);
        drive_op(ld, st, f3, a, wd);
        chk("exe_ready_idle", 128'(bus.exe_ready_o), 128'(1));
        e.c0 = cyc;
        wbq.push_back(e);
        tgt = n_done + 1;
        @(negedge clk);
        idle_op();
        n = 0;
        while (n_done < tgt && n < 300) begin
            chk("exe_ready_busy", 128'(bus.exe_ready_o), 128'(0));
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("op_timeout", 128'(1), 128'(0));
            wbq.delete(); mq.delete();
        end
    endtask

    // Memory model: grants requests (with optional stalls), applies writes, returns reads
    initial begin
        bit in_req = 0, pend = 0;
        int stall = 0, rcnt = 0, w;
        logic [31:0] rdat = 0;
        logic [68:0] cur, snap = 0;
        mem_exp_t e;
        bus.mem_ready_i = 0; bus.mem_resp_v_i = 0; bus.mem_rdata_i = 0;
        forever begin
            @(negedge clk);
            bus.mem_ready_i = 1'b0;
            bus.mem_resp_v_i = 1'b0;
            bus.mem_rdata_i = $urandom;
            if (pend) begin
                if (rcnt == 0) begin
                    bus.mem_resp_v_i = 1'b1; bus.mem_rdata_i = rdat; pend = 0;
                end else rcnt--;
            end
            if (!rst_n) in_req = 0;
            else if (bus.mem_v_o) begin
                cur = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wmask_o, bus.mem_wdata_o};
                if (!in_req) begin
                    in_req = 1; snap = cur;
                    stall = (mode == 0) ? 0 : (mode == 2) ? fix_stall : int'($urandom_range(0, 3));
                end else chk("mem_hold", 128'(cur), 128'(snap));
                if (stall > 0) stall--;
                else begin
                    bus.mem_ready_i = 1'b1; in_req = 0;
                    if (mq.size() == 0) chk("mem_unexpected", 128'(1), 128'(0));
                    else begin
                        e = mq.pop_front();
                        chk("mem_we", 128'(bus.mem_we_o), 128'(e.we));
                        chk("mem_addr", 128'(bus.mem_addr_o), 128'(e.addr));
                        if (e.we) begin
                            chk("mem_wmask", 128'(bus.mem_wmask_o), 128'(e.mask));
                            chk("mem_wdata", 128'(bus.mem_wdata_o), 128'(e.wdata));
                        end
                    end
                    w = int'((bus.mem_addr_o - 32'h100) >> 2);
                    if (w >= 0 && w < 128) begin
                        if (bus.mem_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.mem_wmask_o[b]) dmem[w][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
                        end else begin
                            pend = 1; rdat = dmem[w];
                            rcnt = (mode == 0) ? 0 : (mode == 2) ? fix_lat : int'($urandom_range(0, 4));
                        end
                    end
                end
            end
        end
    end

    // Writeback monitor: pops the expected result on the first valid cycle
    initial begin
        bit busy = 0, acc = 0;
        int st = 0;
        logic [32:0] snapw = 0;
        wb_exp_t e;
        bus.wb_ready_i = 0;
        forever begin
            @(negedge clk);
            if (acc) begin
                acc = 0; busy = 0;
                chk("wb_single", 128'(bus.wb_v_o), 128'(0));
            end
            bus.wb_ready_i = 1'b0;
            if (!rst_n) busy = 0;
            else if (bus.wb_v_o) begin
                if (!busy) begin
                    busy = 1; snapw = {bus.wb_err_o, bus.wb_data_o};
                    if (wbq.size() == 0) chk("wb_unexpected", 128'(1), 128'(0));
                    else begin
                        e = wbq.pop_front();
                        chk("wb_data", 128'(bus.wb_data_o), 128'(e.data));
                        chk("wb_err", 128'(bus.wb_err_o), 128'(e.err));
                        if (e.lat >= 0) chk("wb_latency", 128'(cyc - e.c0), 128'(e.lat));
                    end
                    st = (mode == 0) ? 0 : (mode == 2) ? fix_wbst : int'($urandom_range(0, 2));
                end else chk("wb_hold", 128'({bus.wb_err_o, bus.wb_data_o}), 128'(snapw));
                if (st > 0) st--;
                else begin
                    bus.wb_ready_i = 1'b1; acc = 1; n_done++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_exp_t e;
        int seen, r, sz;
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] a;
        idle_op();
        for (int i = 0; i < 128; i++) set_word(256 + 4*i, $urandom);
        repeat (3) @(negedge clk);
        chk("reset_state",
            128'({bus.exe_ready_o, bus.mem_v_o, bus.mem_we_o, bus.wb_v_o, bus.wb_err_o,
                  bus.mem_addr_o, bus.mem_wmask_o, bus.mem_wdata_o, bus.wb_data_o}),
            128'({1'b1, 4'b0, 32'd0, 4'd0, 32'd0, 32'd0}));
        rst_n = 1'b1;

        // Directed zero-wait cases
        mode = 0;
        set_word(32'h100, 32'hDEADBEEF);
        issue(1, 0, 3'b010, 32'h100, 0);
        set_word(32'h100, 32'h80112233);
        issue(1, 0, 3'b000, 32'h103, 0);
        issue(1, 0, 3'b100, 32'h103, 0);
        issue(1, 0, 3'b001, 32'h102, 0);
        issue(0, 1, 3'b000, 32'h201, 32'h000000A5);
        issue(0, 1, 3'b001, 32'h202, 32'h00001234);
        issue(1, 0, 3'b010, 32'h200, 0);
        issue(1, 0, 3'b010, 32'h102, 0);
        issue(0, 1, 3'b001, 32'h101, 32'h5555);
        issue(0, 1, 3'b100, 32'h200, 32'h77);
        issue(1, 1, 3'b010, 32'h200, 0);
        issue(0, 0, 3'b010, 32'h200, 0);
        issue(1, 0, 3'b011, 32'h200, 0);

        // Stalled memory grant, late response, stalled writeback
        mode = 2; fix_stall = 3; fix_lat = 3; fix_wbst = 2;
        issue(1, 0, 3'b010, 32'h104, 0);
        issue(0, 1, 3'b010, 32'h108, 32'hCAFEF00D);
        issue(1, 0, 3'b101, 32'h10A, 0);

        // Reset while waiting for read data; the stray response must be ignored
        fix_stall = 0; fix_lat = 10; fix_wbst = 0;
        expect_op(1, 0, 3'b010, 32'h10C, 0, e);
        @(negedge clk); drive_op(1, 0, 3'b010, 32'h10C, 0);
        @(negedge clk); idle_op();
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        chk("rst_exe_ready", 128'(bus.exe_ready_o), 128'(1));
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.wb_v_o) seen++;
        end
        chk("rst_no_wb", 128'(seen), 128'(0));
        mode = 0;
        issue(1, 0, 3'b010, 32'h10C, 0);

        // Randomized ops
        repeat (200) begin
            mode = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            ld = (r < 9) || (r == 18);
            st = (r >= 9 && r < 19);
            if ($urandom_range(0, 4) != 0) begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end else f3 = 3'($urandom);
            a = 32'h100 + ($urandom % 32'h200);
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            issue(ld, st, f3, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
